pong_game_ctrl: RTL and testbench

Parametrised game-flow controller for the pong design. It generalises the fixed new/play/over sequencing to N players, with per-player lives and scores, a serve delay, pause, a timed game-over screen and a winner report. It also owns the pixel-rate output colour register, muxing text, graphics and background. It sits between the debounced button logic and vga_sync/pong_graph at the top level.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_rgb_reg.sv | 46 ++++
 rtl/pong_game_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and widths for the pong game-flow controller.
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int LIVES_W = 3;
    localparam int RALLY_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

    localparam logic [RALLY_W-1:0] RALLY_MAX = '1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pong_rgb_reg.sv
// Pixel-rate colour register: blanking, then text over graphics over background.
module pong_rgb_reg #(
    parameter int               RGB_W  = 3,
    parameter logic [RGB_W-1:0] BG_RGB = RGB_W'(3'b110)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pixel_tick,
    input  logic             video_on,
    input  logic             graph_on,
    input  logic [RGB_W-1:0] graph_rgb,
    input  logic             text_on,
    input  logic [RGB_W-1:0] text_rgb,
    output logic [RGB_W-1:0] rgb
);

    logic [RGB_W-1:0] rgb_q, rgb_d;

    // Select the next colour; hold the current one between pixel enables.
    always_comb begin
        rgb_d = rgb_q;
        if (pixel_tick) begin
            if (!video_on) begin
                rgb_d = '0;
            end else if (text_on) begin
                rgb_d = text_rgb;
            end else if (graph_on) begin
                rgb_d = graph_rgb;
            end else begin
                rgb_d = BG_RGB;
            end
        end
    end

    // Colour register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb = rgb_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow controller: start/serve/play/pause/over sequencing for N players,
// lives, scores, rally counter, winner report and the output colour register.
// All event inputs (frame_tick, hit, miss) are single-clk pulses; the buttons
// are level signals whose rising edges are detected here.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int               N_PLAYERS    = 2,
    parameter int               BTN_W        = 2,
    parameter int               RGB_W        = 3,
    parameter int               LIVES        = 3,
    parameter int               WIN_SCORE    = 9,
    parameter int               SERVE_FRAMES = 60,
    parameter int               OVER_FRAMES  = 120,
    parameter logic [RGB_W-1:0] BG_RGB       = RGB_W'(3'b110)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_PLAYERS*BTN_W-1:0]   btn,
    input  logic                         pause_btn,
    input  logic                         frame_tick,
    input  logic                         hit,
    input  logic [N_PLAYERS-1:0]         miss,
    input  logic                         video_on,
    input  logic                         pixel_tick,
    input  logic                         graph_on,
    input  logic [RGB_W-1:0]             graph_rgb,
    input  logic                         text_on,
    input  logic [RGB_W-1:0]             text_rgb,
    output logic                         gra_still,
    output logic [2:0]                   state,
    output logic [N_PLAYERS*SCORE_W-1:0] score,
    output logic [N_PLAYERS*LIVES_W-1:0] lives,
    output logic [RALLY_W-1:0]           rally,
    output logic                         game_over,
    output logic [1:0]                   winner,
    output logic [RGB_W-1:0]             rgb
);

    localparam int                  FRAME_MAX  = max_int(SERVE_FRAMES, OVER_FRAMES);
    localparam int                  FCNT_W     = $clog2(FRAME_MAX + 1);
    localparam logic [FCNT_W-1:0]   SERVE_CNT  = FCNT_W'(SERVE_FRAMES);
    localparam logic [FCNT_W-1:0]   OVER_CNT   = FCNT_W'(OVER_FRAMES);
    localparam logic [SCORE_W-1:0]  WIN_S      = SCORE_W'(WIN_SCORE);
    localparam logic [LIVES_W-1:0]  LIVES_INIT = LIVES_W'(LIVES);

    game_state_e state_q, state_d;

    logic [N_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d, score_miss;
    logic [N_PLAYERS-1:0][LIVES_W-1:0] lives_q, lives_d, lives_miss;
    logic [RALLY_W-1:0]                rally_q, rally_d;
    logic [FCNT_W-1:0]                 frame_cnt_q, frame_cnt_d, frame_cnt_nxt;
    logic                              game_over_q, game_over_d;
    logic [1:0]                        winner_q, winner_d;
    logic                              btn_any_q, btn_any_d;
    logic                              pause_q, pause_d;

    logic                 start_edge, pause_edge, any_miss, game_end;
    logic                 serve_done, over_done;
    logic [SCORE_W-1:0]   best_score;
    logic [1:0]           best_idx;

    // Rising-edge detection of the OR of all player buttons and of pause.
    assign btn_any_d     = |btn;
    assign pause_d       = pause_btn;
    assign start_edge    = btn_any_d & ~btn_any_q;
    assign pause_edge    = pause_d & ~pause_q;
    assign any_miss      = |miss;
    assign frame_cnt_nxt = frame_cnt_q + FCNT_W'(1);
    assign serve_done    = frame_tick && (frame_cnt_nxt == SERVE_CNT);
    assign over_done     = frame_tick && (frame_cnt_nxt == OVER_CNT);

    // Lives/scores as they would look after this cycle's miss, plus end-of-game test.
    always_comb begin
        score_miss = score_q;
        lives_miss = lives_q;
        game_end   = 1'b0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (miss[i]) begin
                if (lives_q[i] != '0) begin
                    lives_miss[i] = lives_q[i] - LIVES_W'(1);
                end
            end else if (N_PLAYERS > 1) begin
                if (score_q[i] < WIN_S) begin
                    score_miss[i] = score_q[i] + SCORE_W'(1);
                end
            end
            if ((lives_miss[i] == '0) || (score_miss[i] == WIN_S)) begin
                game_end = 1'b1;
            end
        end
    end

    // Winner candidate: lowest-index player holding the highest post-miss score.
    always_comb begin
        best_score = score_miss[0];
        best_idx   = 2'd0;
        for (int i = 1; i < N_PLAYERS; i++) begin
            if (score_miss[i] > best_score) begin
                best_score = score_miss[i];
                best_idx   = 2'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in PLAY a miss outranks a pause edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_edge) state_d = ST_SERVE;
            ST_SERVE: if (serve_done) state_d = ST_PLAY;
            ST_PLAY: begin
                if (any_miss) begin
                    state_d = game_end ? ST_OVER : ST_SERVE;
                end else if (pause_edge) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: if (pause_edge) state_d = ST_PLAY;
            ST_OVER:  if (over_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        gra_still = 1'b1;
        if (state_q == ST_PLAY) begin
            gra_still = 1'b0;
        end
        state = state_q;
    end

    // Datapath: scores, lives, rally, frame counter, winner and game_over pulse.
    always_comb begin
        score_d     = score_q;
        lives_d     = lives_q;
        rally_d     = rally_q;
        winner_d    = winner_q;
        frame_cnt_d = frame_cnt_q;
        game_over_d = 1'b0;

        // Only SERVE and OVER time anything, so the count runs there alone.
        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (frame_tick && ((state_q == ST_SERVE) || (state_q == ST_OVER))) begin
            frame_cnt_d = frame_cnt_nxt;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    score_d = '0;
                    lives_d = {N_PLAYERS{LIVES_INIT}};
                    rally_d = '0;
                end
            end
            ST_PLAY: begin
                if (any_miss) begin
                    score_d = score_miss;
                    lives_d = lives_miss;
                end else if (!pause_edge && hit) begin
                    if (rally_q != RALLY_MAX) begin
                        rally_d = rally_q + RALLY_W'(1);
                    end
                    // A lone player scores on paddle hits instead of opponent misses.
                    if ((N_PLAYERS == 1) && (score_q[0] < WIN_S)) begin
                        score_d[0] = score_q[0] + SCORE_W'(1);
                    end
                end
            end
            default: ;
        endcase

        if ((state_d == ST_SERVE) && (state_q != ST_SERVE)) begin
            rally_d = '0;
        end
        if ((state_d == ST_OVER) && (state_q != ST_OVER)) begin
            game_over_d = 1'b1;
            winner_d    = best_idx;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q     <= '0;
            lives_q     <= {N_PLAYERS{LIVES_INIT}};
            rally_q     <= '0;
            frame_cnt_q <= '0;
            game_over_q <= 1'b0;
            winner_q    <= 2'd0;
            btn_any_q   <= 1'b0;
            pause_q     <= 1'b0;
        end else begin
            score_q     <= score_d;
            lives_q     <= lives_d;
            rally_q     <= rally_d;
            frame_cnt_q <= frame_cnt_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            btn_any_q   <= btn_any_d;
            pause_q     <= pause_d;
        end
    end

    assign score     = score_q;
    assign lives     = lives_q;
    assign rally     = rally_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

    pong_rgb_reg #(
        .RGB_W  (RGB_W),
        .BG_RGB (BG_RGB)
    ) u_rgb_reg (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (pixel_tick),
        .video_on   (video_on),
        .graph_on   (graph_on),
        .graph_rgb  (graph_rgb),
        .text_on    (text_on),
        .text_rgb   (text_rgb),
        .rgb        (rgb)
    );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl. WIN_SCORE is lowered to 2 so a win by
// score is reachable before any player runs out of its 3 lives.
module tb_pong_game_ctrl;

    localparam int NP = 2;
    localparam int BW = 2;
    localparam int RW = 3;

    logic            clk;
    logic            reset;
    logic [NP*BW-1:0] btn;
    logic            pause_btn;
    logic            frame_tick;
    logic            hit;
    logic [NP-1:0]   miss;
    logic            video_on;
    logic            pixel_tick;
    logic            graph_on;
    logic [RW-1:0]   graph_rgb;
    logic            text_on;
    logic [RW-1:0]   text_rgb;
    logic            gra_still;
    logic [2:0]      state;
    logic [NP*4-1:0] score;
    logic [NP*3-1:0] lives;
    logic [7:0]      rally;
    logic            game_over;
    logic [1:0]      winner;
    logic [RW-1:0]   rgb;

    int checks   = 0;
    int failures = 0;

    pong_game_ctrl #(
        .N_PLAYERS    (NP),
        .BTN_W        (BW),
        .RGB_W        (RW),
        .LIVES        (3),
        .WIN_SCORE    (2),
        .SERVE_FRAMES (60),
        .OVER_FRAMES  (120),
        .BG_RGB       (3'b110)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .pause_btn  (pause_btn),
        .frame_tick (frame_tick),
        .hit        (hit),
        .miss       (miss),
        .video_on   (video_on),
        .pixel_tick (pixel_tick),
        .graph_on   (graph_on),
        .graph_rgb  (graph_rgb),
        .text_on    (text_on),
        .text_rgb   (text_rgb),
        .gra_still  (gra_still),
        .state      (state),
        .score      (score),
        .lives      (lives),
        .rally      (rally),
        .game_over  (game_over),
        .winner     (winner),
        .rgb        (rgb)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_frames(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic start_game();
        btn = 4'b0001;
        tick();
        btn = '0;
    endtask

    task automatic pulse_miss(input logic [NP-1:0] m);
        miss = m;
        tick();
        miss = '0;
    endtask

    task automatic pulse_pause();
        pause_btn = 1'b1;
        tick();
        pause_btn = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (gra_still !== 1'b1) begin failures++; $display("FAIL rst_still got=%0b exp=1", gra_still); end
        checks++; if (score !== 8'h00) begin failures++; $display("FAIL rst_score got=%h exp=00", score); end
        checks++; if (lives !== 6'h1B) begin failures++; $display("FAIL rst_lives got=%h exp=1b", lives); end
        checks++; if (rally !== 8'd0) begin failures++; $display("FAIL rst_rally got=%0d exp=0", rally); end
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL rst_gameover got=%0b exp=0", game_over); end
        checks++; if (winner !== 2'd0) begin failures++; $display("FAIL rst_winner got=%0d exp=0", winner); end
        checks++; if (rgb !== 3'b000) begin failures++; $display("FAIL rst_rgb got=%b exp=000", rgb); end
    endtask

    task automatic test_start();
        start_game();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", state); end
        checks++; if (gra_still !== 1'b1) begin failures++; $display("FAIL serve_still got=%0b exp=1", gra_still); end
        pulse_frames(59);
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL serve59_state got=%0d exp=1", state); end
        pulse_frames(1);
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL serve60_state got=%0d exp=2", state); end
        checks++; if (gra_still !== 1'b0) begin failures++; $display("FAIL play_still got=%0b exp=0", gra_still); end
        checks++; if (lives !== 6'h1B) begin failures++; $display("FAIL play_lives got=%h exp=1b", lives); end
        checks++; if (score !== 8'h00) begin failures++; $display("FAIL play_score got=%h exp=00", score); end
    endtask

    task automatic test_hit_miss();
        hit = 1'b1;
        tick();
        tick();
        tick();
        hit = 1'b0;
        checks++; if (rally !== 8'd3) begin failures++; $display("FAIL hit_rally got=%0d exp=3", rally); end
        pulse_miss(2'b01);
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL miss_state got=%0d exp=1", state); end
        checks++; if (lives !== 6'h1A) begin failures++; $display("FAIL miss_lives got=%h exp=1a", lives); end
        checks++; if (score !== 8'h10) begin failures++; $display("FAIL miss_score got=%h exp=10", score); end
        checks++; if (rally !== 8'd0) begin failures++; $display("FAIL miss_rally got=%0d exp=0", rally); end
    endtask

    task automatic test_win_score();
        pulse_frames(60);
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL win_play got=%0d exp=2", state); end
        pulse_miss(2'b01);
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL win_state got=%0d exp=4", state); end
        checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL win_gameover got=%0b exp=1", game_over); end
        checks++; if (winner !== 2'd1) begin failures++; $display("FAIL win_winner got=%0d exp=1", winner); end
        checks++; if (score !== 8'h20) begin failures++; $display("FAIL win_score got=%h exp=20", score); end
        checks++; if (lives !== 6'h19) begin failures++; $display("FAIL win_lives got=%h exp=19", lives); end
        tick();
        checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL win_pulse got=%0b exp=0", game_over); end
        pulse_frames(119);
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL over119_state got=%0d exp=4", state); end
        pulse_frames(1);
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL over120_state got=%0d exp=0", state); end
        checks++; if (score !== 8'h20) begin failures++; $display("FAIL idle_score got=%h exp=20", score); end
        start_game();
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL restart_state got=%0d exp=1", state); end
        checks++; if (score !== 8'h00) begin failures++; $display("FAIL restart_score got=%h exp=00", score); end
        checks++; if (lives !== 6'h1B) begin failures++; $display("FAIL restart_lives got=%h exp=1b", lives); end
    endtask

    task automatic test_both_miss();
        pulse_frames(60);
        pulse_miss(2'b11);
        checks++; if (lives !== 6'h12) begin failures++; $display("FAIL both1_lives got=%h exp=12", lives); end
        checks++; if (score !== 8'h00) begin failures++; $display("FAIL both1_score got=%h exp=00", score); end
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL both1_state got=%0d exp=1", state); end
        pulse_frames(60);
        pulse_miss(2'b11);
        checks++; if (lives !== 6'h09) begin failures++; $display("FAIL both2_lives got=%h exp=09", lives); end
        pulse_frames(60);
        pulse_miss(2'b11);
        checks++; if (lives !== 6'h00) begin failures++; $display("FAIL both3_lives got=%h exp=00", lives); end
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL both3_state got=%0d exp=4", state); end
        checks++; if (game_over !== 1'b1) begin failures++; $display("FAIL both3_gameover got=%0b exp=1", game_over); end
        checks++; if (winner !== 2'd0) begin failures++; $display("FAIL both3_winner got=%0d exp=0", winner); end
    endtask

    task automatic test_pause();
        do_reset();
        start_game();
        pulse_frames(60);
        pulse_pause();
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL pause_state got=%0d exp=3", state); end
        checks++; if (gra_still !== 1'b1) begin failures++; $display("FAIL pause_still got=%0b exp=1", gra_still); end
        tick();
        hit  = 1'b1;
        miss = 2'b01;
        tick();
        hit  = 1'b0;
        miss = 2'b00;
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL paused_state got=%0d exp=3", state); end
        checks++; if (rally !== 8'd0) begin failures++; $display("FAIL paused_rally got=%0d exp=0", rally); end
        checks++; if (lives !== 6'h1B) begin failures++; $display("FAIL paused_lives got=%h exp=1b", lives); end
        checks++; if (score !== 8'h00) begin failures++; $display("FAIL paused_score got=%h exp=00", score); end
        pulse_pause();
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL resume_state got=%0d exp=2", state); end
        tick();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++; if (rally !== 8'd1) begin failures++; $display("FAIL resume_rally got=%0d exp=1", rally); end
        pause_btn = 1'b1;
        miss      = 2'b10;
        tick();
        pause_btn = 1'b0;
        miss      = 2'b00;
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL pausemiss_state got=%0d exp=1", state); end
        checks++; if (lives !== 6'h13) begin failures++; $display("FAIL pausemiss_lives got=%h exp=13", lives); end
        checks++; if (score !== 8'h01) begin failures++; $display("FAIL pausemiss_score got=%h exp=01", score); end
    endtask

    task automatic test_rally_sat();
        pulse_frames(60);
        hit = 1'b1;
        for (int k = 0; k < 260; k++) tick();
        hit = 1'b0;
        checks++; if (rally !== 8'd255) begin failures++; $display("FAIL rally_sat got=%0d exp=255", rally); end
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL rally_state got=%0d exp=2", state); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        miss  = 2'b11;
        hit   = 1'b1;
        tick();
        reset = 1'b0;
        miss  = 2'b00;
        hit   = 1'b0;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", state); end
        checks++; if (rally !== 8'd0) begin failures++; $display("FAIL midrst_rally got=%0d exp=0", rally); end
        checks++; if (lives !== 6'h1B) begin failures++; $display("FAIL midrst_lives got=%h exp=1b", lives); end
        checks++; if (score !== 8'h00) begin failures++; $display("FAIL midrst_score got=%h exp=00", score); end
    endtask

    task automatic test_rgb();
        video_on   = 1'b1;
        text_on    = 1'b1;
        text_rgb   = 3'b011;
        graph_on   = 1'b1;
        graph_rgb  = 3'b101;
        pixel_tick = 1'b1;
        tick();
        checks++; if (rgb !== 3'b011) begin failures++; $display("FAIL rgb_text got=%b exp=011", rgb); end
        pixel_tick = 1'b0;
        text_on    = 1'b0;
        tick();
        graph_on = 1'b0;
        tick();
        graph_on = 1'b1;
        tick();
        checks++; if (rgb !== 3'b011) begin failures++; $display("FAIL rgb_hold got=%b exp=011", rgb); end
        pixel_tick = 1'b1;
        tick();
        checks++; if (rgb !== 3'b101) begin failures++; $display("FAIL rgb_graph got=%b exp=101", rgb); end
        graph_on = 1'b0;
        tick();
        checks++; if (rgb !== 3'b110) begin failures++; $display("FAIL rgb_bg got=%b exp=110", rgb); end
        video_on = 1'b0;
        text_on  = 1'b1;
        tick();
        checks++; if (rgb !== 3'b000) begin failures++; $display("FAIL rgb_blank got=%b exp=000", rgb); end
        pixel_tick = 1'b0;
    endtask

    // Scenario sequence and final report
    initial begin
        reset      = 1'b1;
        btn        = '0;
        pause_btn  = 1'b0;
        frame_tick = 1'b0;
        hit        = 1'b0;
        miss       = '0;
        video_on   = 1'b0;
        pixel_tick = 1'b0;
        graph_on   = 1'b0;
        graph_rgb  = '0;
        text_on    = 1'b0;
        text_rgb   = '0;

        test_reset();
        test_start();
        test_hit_miss();
        test_win_score();
        test_both_miss();
        test_pause();
        test_rally_sat();
        test_reset_mid();
        test_rgb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
